// File: rtl/fdiv_seq.sv
// fdiv_seq: sequential IEEE-754 single-precision divider, out_div = num1 / num2.
// One quotient bit per cycle (restoring division), start/ready/done handshake.
// Denormals, infinities and NaNs are not recognised; exponent 255 is ordinary.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        request, sampled only while ready=1
//   num1, num2   dividend / divisor, sampled on the accepting edge
//   ready        idle, able to accept start
//   done         one-cycle pulse, out_div valid from this cycle on
//   out_div      quotient, held until the next result
//   div_by_zero  divisor was zero, held alongside out_div
//
// Build option: define FDIV_ROUND_EN for round-to-nearest-even,
// otherwise the mantissa is truncated. Latency is the same in both builds.
module fdiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    output logic        ready,
    output logic        done,
    output logic [31:0] out_div,
    output logic        div_by_zero
);

    localparam int unsigned MW   = 23;  // stored mantissa width
    localparam int unsigned RW   = 25;  // partial remainder width
    localparam int unsigned QW   = 26;  // quotient width
    localparam int unsigned CW   = 5;   // iteration counter width
    localparam int unsigned EW   = 10;  // signed working exponent width
    localparam logic [CW-1:0] LAST_ITER = CW'(25);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_NORM,
        ST_FIN
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  sign_q, sign_d;
    logic signed [EW-1:0]  e_q, e_d;
    logic                  m1_lsb_q, m1_lsb_d;
    logic [MW:0]           m2_q, m2_d;
    logic [RW-1:0]         rem_q, rem_d;
    logic [QW-1:0]         q_q, q_d;
    logic                  spec_dbz_q, spec_dbz_d;
    logic [31:0]           out_q, out_d;
    logic                  dbz_q, dbz_d;
    logic                  done_q, done_d;
    logic                  ready_q, ready_d;

    // Operand decode at the accepting edge
    logic                  zero1_c, zero2_c;
    logic signed [EW-1:0]  e_init_c;

    assign zero1_c  = (num1[30:0] == 31'd0);
    assign zero2_c  = (num2[30:0] == 31'd0);
    assign e_init_c = EW'({2'b00, num1[30:23]}) - EW'({2'b00, num2[30:23]}) + EW'(127);

    // One restoring-division step; m1 enters the remainder pre-shifted right by
    // one so the first step's shift brings m1's LSB back in and yields q[25].
    logic [RW-1:0] shifted_c, diff_c;
    logic          ge_c;

    always_comb begin
        shifted_c = {rem_q[RW-2:0], (cnt_q == '0) ? m1_lsb_q : 1'b0};
        ge_c      = (shifted_c >= {1'b0, m2_q});
        diff_c    = shifted_c - {1'b0, m2_q};
    end

    // Normalisation, rounding and range check of the finished quotient
    logic [MW-1:0]         mant_c, mant_f_c;
    logic                  guard_c, sticky_c, inc_c;
    logic [MW:0]           mant_r_c;
    logic signed [EW-1:0]  e_n_c, e_f_c;
    logic [31:0]           norm_res_c;

    always_comb begin
        if (q_q[QW-1]) begin
            mant_c   = q_q[24:2];
            guard_c  = q_q[1];
            sticky_c = q_q[0] | (|rem_q);
            e_n_c    = e_q;
        end else begin
            mant_c   = q_q[23:1];
            guard_c  = q_q[0];
            sticky_c = |rem_q;
            e_n_c    = e_q - EW'(1);
        end
    end

`ifdef FDIV_ROUND_EN
    assign inc_c = guard_c & (sticky_c | mant_c[0]);
`else
    logic round_bits_unused;
    assign round_bits_unused = guard_c | sticky_c;
    assign inc_c             = 1'b0;
`endif

    always_comb begin
        mant_r_c = {1'b0, mant_c} + (MW+1)'(inc_c);
        if (mant_r_c[MW]) begin
            mant_f_c = '0;
            e_f_c    = e_n_c + EW'(1);
        end else begin
            mant_f_c = mant_r_c[MW-1:0];
            e_f_c    = e_n_c;
        end
        if (e_f_c >= $signed(EW'(255))) begin
            norm_res_c = {sign_q, 8'hFF, 23'd0};
        end else if (e_f_c <= $signed(EW'(0))) begin
            norm_res_c = {sign_q, 31'd0};
        end else begin
            norm_res_c = {sign_q, e_f_c[7:0], mant_f_c};
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        e_d        = e_q;
        m1_lsb_d   = m1_lsb_q;
        m2_d       = m2_q;
        rem_d      = rem_q;
        q_d        = q_q;
        spec_dbz_d = spec_dbz_q;
        out_d      = out_q;
        dbz_d      = dbz_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sign_d     = num1[31] ^ num2[31];
                    e_d        = e_init_c;
                    m1_lsb_d   = num1[0];
                    m2_d       = {1'b1, num2[22:0]};
                    rem_d      = {2'b00, 1'b1, num1[22:1]};
                    q_d        = '0;
                    cnt_d      = '0;
                    spec_dbz_d = zero2_c;
                    state_d    = (zero1_c || zero2_c) ? ST_FIN : ST_DIV;
                end
            end
            ST_DIV: begin
                rem_d = ge_c ? diff_c : shifted_c;
                q_d   = {q_q[QW-2:0], ge_c};
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_NORM;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_NORM: begin
                out_d   = norm_res_c;
                dbz_d   = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_FIN: begin
                out_d   = spec_dbz_q ? {sign_q, 8'hFF, 23'd0} : {sign_q, 31'd0};
                dbz_d   = spec_dbz_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            e_q        <= '0;
            m1_lsb_q   <= 1'b0;
            m2_q       <= '0;
            rem_q      <= '0;
            q_q        <= '0;
            spec_dbz_q <= 1'b0;
            out_q      <= '0;
            dbz_q      <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            e_q        <= e_d;
            m1_lsb_q   <= m1_lsb_d;
            m2_q       <= m2_d;
            rem_q      <= rem_d;
            q_q        <= q_d;
            spec_dbz_q <= spec_dbz_d;
            out_q      <= out_d;
            dbz_q      <= dbz_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign out_div     = out_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed bench for fdiv_seq: table of vectors plus hand-written handshake,
// back-to-back, ignored-start and mid-operation reset sequences.
module tb_fdiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] num1, num2;
    logic        ready, done, div_by_zero;
    logic [31:0] out_div;

    int errors = 0;
    int checks = 0;

    fdiv_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num1        (num1),
        .num2        (num2),
        .ready       (ready),
        .done        (done),
        .out_div     (out_div),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_trunc;
        logic [31:0] exp_rne;
        logic        dbz;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Issue one request from a negedge and follow it to its done pulse.
    // Returns at the negedge inside the done cycle with start low.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_dbz, input int exp_lat);
        logic [31:0] prev;
        logic        busy_bad, held_bad;
        int          lat;
        prev     = out_div;
        busy_bad = 1'b0;
        held_bad = 1'b0;
        lat      = -1;
        start = 1'b1; num1 = a; num2 = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; num1 = $urandom; num2 = $urandom;
        if (ready !== 1'b0 || done !== 1'b0) busy_bad = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            if (ready !== 1'b0) busy_bad = 1'b1;
            if (out_div !== prev) held_bad = 1'b1;
        end
        chk({name, "_out"}, out_div, exp_res);
        chk({name, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({name, "_ready_on_done"}, 32'(ready), 32'd1);
        chk({name, "_busy_flags"}, {30'd0, busy_bad, held_bad}, 32'd0);
    endtask

    vec_t tbl[12];

    initial begin
        int          ndone;
        int          lat;
        logic [31:0] res;
        logic [31:0] exp;

        tbl[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, 1'b0, 27};
        tbl[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 32'h3EAAAAAB, 1'b0, 27};
        tbl[2]  = '{32'h3F800000, 32'h3FC00000, 32'h3F2AAAAA, 32'h3F2AAAAB, 1'b0, 27};
        tbl[3]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 32'hC0400000, 1'b0, 27};
        tbl[4]  = '{32'hBF800000, 32'hC0400000, 32'h3EAAAAAA, 32'h3EAAAAAB, 1'b0, 27};
        tbl[5]  = '{32'h40E00000, 32'h40400000, 32'h40155555, 32'h40155555, 1'b0, 27};
        tbl[6]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 27};
        tbl[7]  = '{32'h7F000000, 32'h00800000, 32'h7F800000, 32'h7F800000, 1'b0, 27};
        tbl[8]  = '{32'h00800000, 32'h7F000000, 32'h00000000, 32'h00000000, 1'b0, 27};
        tbl[9]  = '{32'h80000000, 32'h40000000, 32'h80000000, 32'h80000000, 1'b0, 1};
        tbl[10] = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h7F800000, 1'b1, 1};
        tbl[11] = '{32'hC0000000, 32'h00000000, 32'hFF800000, 32'hFF800000, 1'b1, 1};

        rst = 1'b1; start = 1'b0; num1 = '0; num2 = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_out", out_div, 32'd0);
        chk("reset_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Consecutive table rows start inside the previous done cycle.
        for (int i = 0; i < 12; i++) begin
`ifdef FDIV_ROUND_EN
            exp = tbl[i].exp_rne;
`else
            exp = tbl[i].exp_trunc;
`endif
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, exp, tbl[i].dbz, tbl[i].lat);
        end
        @(negedge clk);
        chk("done_single_cycle", 32'(done), 32'd0);

        // Back-to-back pair: second start in the first op's done cycle.
        run_op("b2b_first", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 27);
        run_op("b2b_second", 32'hC0E00000, 32'h40400000, 32'hC0155555, 1'b0, 27);
        @(negedge clk);

        // A start pulse mid-operation is ignored.
        start = 1'b1; num1 = 32'h40C00000; num2 = 32'h40000000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        ndone = 0; lat = -1; res = '0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 10) begin
                start = 1'b1; num1 = 32'h3F800000; num2 = 32'h40400000;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                ndone++;
                if (lat < 0) begin
                    lat = i;
                    res = out_div;
                end
            end
        end
        chk("ignored_start_ndone", 32'(ndone), 32'd1);
        chk("ignored_start_lat", 32'(lat), 32'd27);
        chk("ignored_start_out", res, 32'h40400000);

        // Mid-operation reset after a divide-by-zero left the flag set.
        run_op("pre_rst_dbz", 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1);
        @(negedge clk);
        start = 1'b1; num1 = 32'h3F800000; num2 = 32'h40400000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("abort_out", out_div, 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 27);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
